// File: rtl/ir_pkg.sv
// Shared bay-state encoding and bit-count helper for the parking IR occupancy logic.
package ir_pkg;

  typedef enum logic {
    FREE = 1'b0,
    OCC  = 1'b1
  } bay_state_e;

  localparam int MAX_BAYS = 16;

  function automatic logic [4:0] popcount(input logic [MAX_BAYS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_BAYS; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// One-bay bidirectional debouncer: qualifies arrival and departure over consecutive ticks.
module ir_debounce
  import ir_pkg::*;
#(
  parameter int ON_MS  = 100,
  parameter int OFF_MS = 100,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_i,
  input  logic tick_i,
  output logic occupied_o,
  output logic arrive_o,
  output logic depart_o
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_MS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_MS - 1);

  bay_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] thr_last;
  logic             agree;
  logic             arrive_q;
  logic             depart_q;

  always_comb begin
    thr_last = (state_q == OCC) ? OFF_LAST : ON_LAST;
    agree    = (ir_i == logic'(state_q));
  end

  // Any cycle of agreement clears the count, so short glitches never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
    end else begin
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      if (agree) begin
        cnt_q <= '0;
      end else if (tick_i) begin
        if (cnt_q == thr_last) begin
          cnt_q <= '0;
          if (state_q == FREE) begin
            state_q  <= OCC;
            arrive_q <= 1'b1;
          end else begin
            state_q  <= FREE;
            depart_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign occupied_o = (state_q == OCC);
  assign arrive_o   = arrive_q;
  assign depart_o   = depart_q;

endmodule

// File: rtl/ir_bank.sv
// Multi-bay IR occupancy detector: input synchronisers, shared ms tick, per-bay debounce, free count.
module ir_bank
  import ir_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 100000,
  parameter int ON_MS    = 100,
  parameter int OFF_MS   = 100,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           ir,
  output logic [CHANNELS-1:0]           ir_sync,
  output logic [CHANNELS-1:0]           occupied,
  output logic [CHANNELS-1:0]           arrive,
  output logic [CHANNELS-1:0]           depart,
  output logic [$clog2(CHANNELS+1)-1:0] free_count,
  output logic                          full
);

  localparam int             TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam int             FC_W      = $clog2(CHANNELS + 1);

  logic [CHANNELS-1:0] ir_meta_q;
  logic [CHANNELS-1:0] ir_sync_q;
  logic [TW-1:0]       tick_cnt_q;
  logic [TW-1:0]       tick_cnt_d;
  logic                tick;
  logic [CHANNELS-1:0] occ_w;
  logic [MAX_BAYS-1:0] occ_pad;
  logic [FC_W-1:0]     free_count_q;
  logic [FC_W-1:0]     free_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_meta_q <= '0;
      ir_sync_q <= '0;
    end else begin
      ir_meta_q <= ir;
      ir_sync_q <= ir_meta_q;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_bay
    ir_debounce #(
      .ON_MS (ON_MS),
      .OFF_MS(OFF_MS),
      .CNT_W (CNT_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .ir_i      (ir_sync_q[g]),
      .tick_i    (tick),
      .occupied_o(occ_w[g]),
      .arrive_o  (arrive[g]),
      .depart_o  (depart[g])
    );
  end

  // Free count lags occupancy by one cycle so the popcount sits behind a register.
  always_comb begin
    occ_pad      = MAX_BAYS'(occ_w);
    free_count_d = FC_W'(CHANNELS) - FC_W'(popcount(occ_pad));
  end

  always_ff @(posedge clk) begin
    if (rst) free_count_q <= FC_W'(CHANNELS);
    else     free_count_q <= free_count_d;
  end

  assign ir_sync    = ir_sync_q;
  assign occupied   = occ_w;
  assign free_count = free_count_q;
  assign full       = (free_count_q == '0);

endmodule

// File: tb/tb_ir_bank.sv
// Directed bench for ir_bank with CHANNELS=4, TICK_DIV=4, ON_MS=3, OFF_MS=2.
module tb_ir_bank;

  logic       clk;
  logic       rst;
  logic [3:0] ir;
  logic [3:0] ir_sync;
  logic [3:0] occupied;
  logic [3:0] arrive;
  logic [3:0] depart;
  logic [2:0] free_count;
  logic       full;

  int n_checks = 0;
  int n_fail   = 0;
  int arrive_cnt [4];
  int depart_cnt [4];

  ir_bank #(
    .CHANNELS(4),
    .TICK_DIV(4),
    .ON_MS   (3),
    .OFF_MS  (2),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .ir_sync   (ir_sync),
    .occupied  (occupied),
    .arrive    (arrive),
    .depart    (depart),
    .free_count(free_count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      arrive_cnt[i] = 0;
      depart_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (arrive[i] === 1'b1) arrive_cnt[i]++;
      if (depart[i] === 1'b1) depart_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_occ(input int ch, input logic val, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (occupied[ch] !== val && n < maxc);
  endtask

  initial begin
    int n;
    int a0, a1, d0;

    // Reset with all beams broken: nothing may qualify or pulse.
    rst = 1'b1;
    ir  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_pulses", {28'b0, arrive | depart}, 32'h0);
    end
    chk("rst_occ", {28'b0, occupied}, 32'h0);
    chk("rst_free", {29'b0, free_count}, 32'd4);
    chk("rst_full", {31'b0, full}, 32'd0);
    rst = 1'b0;
    ir  = 4'b0000;
    step();
    chk("post_rst_pulses", {28'b0, arrive | depart}, 32'h0);
    steps(6);

    // Arrival on bay 0.
    a0 = arrive_cnt[0];
    ir[0] = 1'b1;
    wait_occ(0, 1'b1, 20, n);
    chk($sformatf("arr_lat_%0d", n), {31'b0, (n >= 11 && n <= 14)}, 32'd1);
    chk("arr_pulse", {28'b0, arrive}, 32'h1);
    chk("arr_sync", {28'b0, ir_sync}, 32'h1);
    step();
    chk("arr_pulse_end", {28'b0, arrive}, 32'h0);
    chk("arr_free", {29'b0, free_count}, 32'd3);
    chk("arr_cnt", arrive_cnt[0] - a0, 32'd1);

    // Glitch rejection on bay 1: 8 cycles high never spans three ticks.
    a1 = arrive_cnt[1];
    for (int r = 0; r < 5; r++) begin
      ir[1] = 1'b1;
      steps(8);
      ir[1] = 1'b0;
      steps(8);
    end
    chk("glitch_occ", {31'b0, occupied[1]}, 32'd0);
    chk("glitch_arr", arrive_cnt[1] - a1, 32'd0);

    // Short dip on occupied bay 0 must not depart.
    d0 = depart_cnt[0];
    ir[0] = 1'b0;
    steps(3);
    ir[0] = 1'b1;
    steps(20);
    chk("dip_occ", {31'b0, occupied[0]}, 32'd1);
    chk("dip_dep", depart_cnt[0] - d0, 32'd0);

    // Real departure of bay 0.
    ir[0] = 1'b0;
    wait_occ(0, 1'b0, 20, n);
    chk($sformatf("dep_lat_%0d", n), {31'b0, (n >= 7 && n <= 10)}, 32'd1);
    chk("dep_pulse", {28'b0, depart}, 32'h1);
    step();
    chk("dep_pulse_end", {28'b0, depart}, 32'h0);
    chk("dep_free", {29'b0, free_count}, 32'd4);
    chk("dep_cnt", depart_cnt[0] - d0, 32'd1);
    steps(6);

    // All four bays arrive together.
    ir = 4'b1111;
    wait_occ(0, 1'b1, 20, n);
    chk("all_occ", {28'b0, occupied}, 32'hF);
    chk("all_arr", {28'b0, arrive}, 32'hF);
    chk("all_free_lag", {29'b0, free_count}, 32'd4);
    chk("all_full_lag", {31'b0, full}, 32'd0);
    step();
    chk("all_free", {29'b0, free_count}, 32'd0);
    chk("all_full", {31'b0, full}, 32'd1);
    chk("all_arr_end", {28'b0, arrive}, 32'h0);

    // Reset part-way through a departure, beams restored.
    d0 = depart_cnt[0];
    ir = 4'b0000;
    steps(3);
    rst = 1'b1;
    ir  = 4'b1111;
    step();
    chk("mid_rst_occ", {28'b0, occupied}, 32'h0);
    chk("mid_rst_free", {29'b0, free_count}, 32'd4);
    chk("mid_rst_full", {31'b0, full}, 32'd0);
    chk("mid_rst_pulses", {28'b0, arrive | depart}, 32'h0);
    step();
    rst = 1'b0;
    wait_occ(0, 1'b1, 20, n);
    chk($sformatf("requal_lat_%0d", n), {31'b0, (n >= 11 && n <= 14)}, 32'd1);
    chk("requal_arr", {28'b0, arrive}, 32'hF);
    chk("mid_no_dep", depart_cnt[0] - d0, 32'd0);
    step();
    chk("requal_full", {31'b0, full}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
